ts_bus_sequencer: RTL

- Bus-cycle sequencer and arbiter in front of the dual-YM2203 Turbosound-FM core.
- Two masters share the core's BDIR/BC/DI write bus:
  - the Z80 port decoder (CPU);
  - a register-write FIFO fed by the MCU/playback side.
- Generates stretched write strobes that survive the core's 2-flop input synchronisers and rising-edge BDIR detect.
- Keeps MCU transactions atomic and invisible to the CPU by restoring the CPU's chip-select/status/FM state and latched register address afterwards.

---
 rtl/ts_bus_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ts_bus_sequencer.sv
// Bus-cycle sequencer/arbiter for the dual-YM2203 Turbosound-FM core.
// CPU port writes and queued MCU register writes share one stretched BDIR bus.
module ts_bus_sequencer #(
    parameter int HOLD       = 4,
    parameter int GAP        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RESET_s,
    input  logic       cpu_wr,
    input  logic       cpu_bc,
    input  logic [7:0] cpu_d,
    input  logic       cpu_rd,
    output logic       cpu_wait,
    input  logic       mcu_push,
    input  logic       mcu_chip,
    input  logic [7:0] mcu_reg,
    input  logic [7:0] mcu_val,
    output logic       mcu_full,
    output logic       mcu_empty,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DI,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(HOLD + GAP + 1);
    localparam logic [CW-1:0] C_HOLD = CW'(HOLD);
    localparam logic [CW-1:0] C_LAST = CW'(HOLD + GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU,
        S_MSEL,
        S_MADR,
        S_MDAT,
        S_RSEL,
        S_RADR
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pend_v;
    logic            r_pend_bc;
    logic [7:0]      r_pend_d;
    logic [7:0]      r_sel;
    logic [7:0]      r_adr;
    logic            r_m_chip;
    logic [7:0]      r_m_reg;
    logic [7:0]      r_m_val;
    logic            r_sw;
    logic            r_bdir;
    logic            r_bc;
    logic [7:0]      r_di;
    logic [AW:0]     r_wp;
    logic [AW:0]     r_rp;
    logic [16:0]     r_mem [FIFO_DEPTH];

    state_t          w_state_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_pop;
    logic            w_launch_cpu;
    logic            w_clr;
    logic            w_bdir_n;
    logic            w_bc_n;
    logic [7:0]      w_di_n;
    logic            w_ch;
    logic [7:0]      w_rg;
    logic [7:0]      w_vl;
    logic            w_sw_n;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_end;
    logic [16:0]     w_head;

    assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty = (r_wp == r_rp);
    assign w_push  = mcu_push && !w_full;
    assign w_head  = r_mem[r_rp[AW-1:0]];
    assign w_end   = (r_cnt == C_LAST);
    // The slot frees on the edge that raises BDIR for the CPU write.
    assign w_clr   = (r_state == S_CPU) && (r_cnt == '0);

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_pop        = 1'b0;
        w_launch_cpu = 1'b0;
        w_ch         = r_m_chip;
        w_rg         = r_m_reg;
        w_vl         = r_m_val;
        w_sw_n       = r_sw;
        w_bc_n       = r_bc;
        w_di_n       = r_di;
        w_bdir_n     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (r_pend_v) begin
                    w_state_n    = S_CPU;
                    w_launch_cpu = 1'b1;
                end else if (!w_empty) begin
                    w_pop              = 1'b1;
                    {w_ch, w_rg, w_vl} = w_head;
                    w_sw_n             = (w_head[16] != r_sel[0]);
                    w_state_n          = w_sw_n ? S_MSEL : S_MADR;
                end
            end
            default: begin
                if (!w_end) begin
                    w_cnt_n = r_cnt + 1'b1;
                end else begin
                    w_cnt_n = CW'(1);
                    unique case (r_state)
                        S_MSEL:  w_state_n = S_MADR;
                        S_MADR:  w_state_n = S_MDAT;
                        S_MDAT:  w_state_n = r_sw ? S_RSEL : S_RADR;
                        S_RSEL:  w_state_n = S_RADR;
                        default: begin
                            w_state_n = S_IDLE;
                            w_cnt_n   = '0;
                        end
                    endcase
                end
            end
        endcase

        if (w_launch_cpu) begin
            w_bc_n = r_pend_bc;
            w_di_n = r_pend_d;
        end else begin
            case (w_state_n)
                S_MSEL: begin
                    w_bc_n = 1'b1;
                    w_di_n = {r_sel[7:1], w_ch};
                end
                S_MADR: begin
                    w_bc_n = 1'b1;
                    w_di_n = w_rg;
                end
                S_MDAT: begin
                    w_bc_n = 1'b0;
                    w_di_n = w_vl;
                end
                S_RSEL: begin
                    w_bc_n = 1'b1;
                    w_di_n = r_sel;
                end
                S_RADR: begin
                    w_bc_n = 1'b1;
                    w_di_n = r_adr;
                end
                default: ;
            endcase
        end

        // Count 0 is the setup cycle after an IDLE launch; BDIR stays low.
        w_bdir_n = (w_state_n != S_IDLE) && (w_cnt_n != '0) &&
                   (w_cnt_n <= C_HOLD);
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_m_chip <= 1'b0;
            r_m_reg  <= 8'h00;
            r_m_val  <= 8'h00;
            r_sw     <= 1'b0;
            r_bdir   <= 1'b0;
            r_bc     <= 1'b0;
            r_di     <= 8'h00;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_m_chip <= w_ch;
            r_m_reg  <= w_rg;
            r_m_val  <= w_vl;
            r_sw     <= w_sw_n;
            r_bdir   <= w_bdir_n;
            r_bc     <= w_bc_n;
            r_di     <= w_di_n;
        end
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            r_pend_v  <= 1'b0;
            r_pend_bc <= 1'b0;
            r_pend_d  <= 8'h00;
        end else if (w_clr) begin
            r_pend_v  <= 1'b0;
        end else if (cpu_wr && !r_pend_v) begin
            r_pend_v  <= 1'b1;
            r_pend_bc <= cpu_bc;
            r_pend_d  <= cpu_d;
        end
    end

    // Shadows track only what the CPU believes; MCU traffic restores them.
    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            r_sel <= 8'hFF;
            r_adr <= 8'h00;
        end else if (w_launch_cpu && r_pend_bc) begin
            if (r_pend_d[7:3] == 5'b11111) begin
                r_sel <= r_pend_d;
            end else begin
                r_adr <= r_pend_d;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= {mcu_chip, mcu_reg, mcu_val};
        end
    end

    assign cpu_wait  = r_pend_v || (cpu_rd && (r_state != S_IDLE));
    assign mcu_full  = w_full;
    assign mcu_empty = w_empty;
    assign BDIR      = r_bdir;
    assign BC        = r_bc;
    assign DI        = r_di;
    assign busy      = (r_state != S_IDLE);

endmodule
